// File: rtl/relu_stream_ctrl_if.sv
// relu_stream_ctrl_if: scheduler/buffer/ReLU handshake bundle for relu_stream_ctrl.
interface relu_stream_ctrl_if #(parameter int ADDR_W = 10);
  logic              start;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic              hold;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              relu_ivalid;
  logic              relu_ovalid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              busy;
  logic              done;
  modport master (output start, len, src_base, dst_base, hold, relu_ovalid,
                  input rd_en, rd_addr, relu_ivalid, wr_en, wr_addr, busy, done);
  modport slave (input start, len, src_base, dst_base, hold, relu_ovalid,
                 output rd_en, rd_addr, relu_ivalid, wr_en, wr_addr, busy, done);
endinterface

// File: rtl/relu_stream_ctrl.sv
// relu_stream_ctrl: streams len words from a source buffer through the ReLU unit into a destination buffer.
module relu_stream_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int RD_LAT   = 1,
  parameter int RELU_LAT = 2
) (
  input logic               clk,
  input logic               rst_n,
  relu_stream_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  if (RD_LAT < 1 || RD_LAT > 4 || RELU_LAT < 1 || RELU_LAT > 4) begin : g_bad_lat
    $error("relu_stream_ctrl: RD_LAT and RELU_LAT must be in 1..4");
  end
  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [RD_LAT-1:0] iv_q, iv_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              accept, rd_en, wr_en;
  always_comb begin
    accept   = state_q == IDLE && bus.start;
    rd_en    = state_q == RUN && rd_cnt_q < len_q && !bus.hold;
    wr_en    = (state_q == RUN || state_q == DRAIN) && bus.relu_ovalid;
    len_d    = accept ? bus.len : len_q;
    src_d    = accept ? bus.src_base : src_q;
    dst_d    = accept ? bus.dst_base : dst_q;
    rd_cnt_d = accept ? '0 : rd_cnt_q + (ADDR_W+1)'(rd_en);
    wr_cnt_d = accept ? '0 : wr_cnt_q + (ADDR_W+1)'(wr_en);
    iv_d     = RD_LAT'({iv_q, rd_en});
    state_d  = state_q == IDLE  ? (bus.start ? (bus.len == '0 ? DONE : RUN) : IDLE)
             : state_q == RUN   ? (rd_cnt_q == len_q ? DRAIN : RUN)
             : state_q == DRAIN ? (wr_cnt_d == len_q ? DONE : DRAIN)
             : IDLE;
    busy_d   = state_d != IDLE;
    done_d   = state_d == DONE;
  end
  // Reset also clears the latched bases so both address outputs read 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      iv_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      iv_q     <= iv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign bus.rd_en       = rd_en;
  assign bus.rd_addr     = src_q + rd_cnt_q[ADDR_W-1:0];
  assign bus.relu_ivalid = iv_q[RD_LAT-1];
  assign bus.wr_en       = wr_en;
  assign bus.wr_addr     = dst_q + wr_cnt_q[ADDR_W-1:0];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_relu_stream_ctrl.sv
// tb_relu_stream_ctrl: directed bench with a buffer + ReLU pipeline model around relu_stream_ctrl.
module tb_relu_stream_ctrl;
  logic clk = 0;
  logic rst_n = 0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  relu_stream_ctrl_if #(.ADDR_W(10)) bus();
  relu_stream_ctrl #(.ADDR_W(10), .RD_LAT(1), .RELU_LAT(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0] src_mem [1024];
  logic [7:0] dst_mem [1024];
  logic [7:0] rdat = 0, d1 = 0, d2 = 0;
  logic       v1 = 0, v2 = 0, inj = 0;
  // Read latency 1, ReLU latency 2; data flows beside the controller.
  always @(posedge clk) begin
    if (bus.rd_en) rdat <= src_mem[bus.rd_addr];
    v1 <= bus.relu_ivalid;
    d1 <= rdat[7] ? 8'd0 : rdat;
    v2 <= v1;
    d2 <= d1;
    if (bus.wr_en) dst_mem[bus.wr_addr] <= d2;
  end
  assign bus.relu_ovalid = v2 | inj;
  int rd_a[$], rd_c[$], wr_a[$], wr_c[$];
  int done_n = 0, done_c = 0;
  logic done_busy = 0;
  always @(negedge clk) begin
    if (bus.rd_en) begin rd_a.push_back(int'(bus.rd_addr)); rd_c.push_back(cyc); end
    if (bus.wr_en) begin wr_a.push_back(int'(bus.wr_addr)); wr_c.push_back(cyc); end
    if (bus.done) begin done_n++; done_c = cyc; done_busy = bus.busy; end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    rd_a.delete(); rd_c.delete(); wr_a.delete(); wr_c.delete();
    done_n = 0;
  endtask
  task automatic start_op(input int l, input int s, input int d, output int t);
    @(posedge clk); #1;
    bus.start = 1; bus.len = 11'(l); bus.src_base = 10'(s); bus.dst_base = 10'(d);
    t = cyc;
    @(posedge clk); #1;
    bus.start = 0;
  endtask
  task automatic wait_done(input string tag);
    int k = 0;
    while (done_n == 0 && k < 300) begin @(posedge clk); k++; end
    if (done_n == 0) chk({tag, "_timeout"}, 0, 1);
  endtask
  logic [7:0] vin [8]  = '{8'h05, 8'hFD, 8'h00, 8'h7F, 8'h80, 8'h01, 8'hFF, 8'h2A};
  logic [7:0] vout [8] = '{8'h05, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h01, 8'h00, 8'h2A};
  int hold_rc [6] = '{1, 2, 6, 7, 8, 9};
  int wrap_r [4]  = '{'h3FE, 'h3FF, 'h000, 'h001};
  int wrap_w [4]  = '{'h3FF, 'h000, 'h001, 'h002};
  initial begin
    int t;
    bus.start = 0; bus.len = 0; bus.src_base = 0; bus.dst_base = 0; bus.hold = 0;
    for (int i = 0; i < 1024; i++) begin src_mem[i] = 8'(i); dst_mem[i] = 8'hAA; end
    for (int i = 0; i < 8; i++) src_mem['h10 + i] = vin[i];
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", 32'(bus.rd_en), 0);
    chk("rst_ivalid", 32'(bus.relu_ivalid), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    @(posedge clk); #1 rst_n = 1;
    // Stray ovalid in IDLE must not write.
    clr();
    inj = 1;
    @(negedge clk);
    chk("stray_wr_en", 32'(bus.wr_en), 0);
    @(posedge clk); #1 inj = 0;
    chk("stray_wr_cnt", 32'(wr_a.size()), 0);
    // Basic stream.
    clr();
    start_op(8, 'h010, 'h200, t);
    @(negedge clk);
    chk("basic_busy_t1", 32'(bus.busy), 1);
    wait_done("basic");
    chk("basic_rd_cnt", 32'(rd_a.size()), 8);
    chk("basic_wr_cnt", 32'(wr_a.size()), 8);
    for (int i = 0; i < 8 && i < rd_a.size() && i < wr_a.size(); i++) begin
      chk($sformatf("basic_rd_addr%0d", i), 32'(rd_a[i]), 32'('h010 + i));
      chk($sformatf("basic_rd_cyc%0d", i), 32'(rd_c[i] - t), 32'(1 + i));
      chk($sformatf("basic_wr_addr%0d", i), 32'(wr_a[i]), 32'('h200 + i));
      chk($sformatf("basic_wr_cyc%0d", i), 32'(wr_c[i] - t), 32'(4 + i));
      chk($sformatf("basic_data%0d", i), 32'(dst_mem['h200 + i]), 32'(vout[i]));
    end
    chk("basic_done_cyc", 32'(done_c - t), 12);
    chk("basic_done_busy", 32'(done_busy), 1);
    @(negedge clk);
    chk("basic_idle_busy", 32'(bus.busy), 0);
    chk("basic_idle_done", 32'(bus.done), 0);
    // Zero length.
    clr();
    start_op(0, 'h050, 'h060, t);
    wait_done("zero");
    chk("zero_done_cyc", 32'(done_c - t), 1);
    repeat (4) @(posedge clk);
    chk("zero_rd_cnt", 32'(rd_a.size()), 0);
    chk("zero_wr_cnt", 32'(wr_a.size()), 0);
    // Hold for three cycles after the second read.
    clr();
    start_op(6, 'h040, 'h080, t);
    repeat (2) @(posedge clk);
    #1 bus.hold = 1;
    repeat (3) @(posedge clk);
    #1 bus.hold = 0;
    wait_done("hold");
    chk("hold_rd_cnt", 32'(rd_a.size()), 6);
    chk("hold_wr_cnt", 32'(wr_a.size()), 6);
    for (int i = 0; i < 6 && i < rd_a.size() && i < wr_a.size(); i++) begin
      chk($sformatf("hold_rd_addr%0d", i), 32'(rd_a[i]), 32'('h040 + i));
      chk($sformatf("hold_rd_cyc%0d", i), 32'(rd_c[i] - t), 32'(hold_rc[i]));
      chk($sformatf("hold_wr_addr%0d", i), 32'(wr_a[i]), 32'('h080 + i));
      chk($sformatf("hold_wr_cyc%0d", i), 32'(wr_c[i] - t), 32'(hold_rc[i] + 3));
    end
    chk("hold_done_cyc", 32'(done_c - t), 13);
    // Address wrap.
    clr();
    start_op(4, 'h3FE, 'h3FF, t);
    wait_done("wrap");
    chk("wrap_rd_cnt", 32'(rd_a.size()), 4);
    chk("wrap_wr_cnt", 32'(wr_a.size()), 4);
    for (int i = 0; i < 4 && i < rd_a.size() && i < wr_a.size(); i++) begin
      chk($sformatf("wrap_rd_addr%0d", i), 32'(rd_a[i]), 32'(wrap_r[i]));
      chk($sformatf("wrap_wr_addr%0d", i), 32'(wr_a[i]), 32'(wrap_w[i]));
    end
    // Second start during RUN is ignored.
    clr();
    start_op(5, 'h010, 'h100, t);
    bus.start = 1; bus.len = 9; bus.src_base = 'h300; bus.dst_base = 'h380;
    @(posedge clk); #1 bus.start = 0;
    wait_done("busy_start");
    repeat (10) @(posedge clk);
    chk("busy_start_rd_cnt", 32'(rd_a.size()), 5);
    chk("busy_start_wr_cnt", 32'(wr_a.size()), 5);
    chk("busy_start_done_n", 32'(done_n), 1);
    chk("busy_start_done_cyc", 32'(done_c - t), 9);
    if (wr_a.size() == 5) chk("busy_start_last_wr", 32'(wr_a[4]), 'h104);
    // Reset after three writes of eight.
    clr();
    start_op(8, 'h020, 'h300, t);
    for (int k = 0; k < 50 && wr_a.size() < 3; k++) @(posedge clk);
    chk("rstmid_reached3", 32'(wr_a.size() >= 3), 1);
    #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("rstmid_busy", 32'(bus.busy), 0);
    chk("rstmid_rd_en", 32'(bus.rd_en), 0);
    chk("rstmid_ivalid", 32'(bus.relu_ivalid), 0);
    chk("rstmid_wr_en", 32'(bus.wr_en), 0);
    chk("rstmid_rd_addr", 32'(bus.rd_addr), 0);
    chk("rstmid_wr_addr", 32'(bus.wr_addr), 0);
    chk("rstmid_done", 32'(bus.done), 0);
    repeat (8) @(posedge clk);
    chk("rstmid_no_done", 32'(done_n), 0);
    clr();
    start_op(3, 'h010, 'h310, t);
    wait_done("rstmid_fresh");
    chk("fresh_wr_cnt", 32'(wr_a.size()), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("fresh_data%0d", i), 32'(dst_mem['h310 + i]), 32'(vout[i]));
    chk("fresh_done_cyc", 32'(done_c - t), 7);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
